// File: rtl/fixp_poly_pipe.sv
// Fixed-point pipeline computing a**POW + ((b*K_MUL) >>> K_SHIFT) - c with a credit-counted result FIFO.
// Define FIXP_POLY_SAT_EN to make every product, the kb term and the final sum saturate instead of wrap.
module fixp_poly_pipe #(
  parameter int WIDTH      = 32,
  parameter int POW        = 5,
  parameter int K_MUL      = 77,
  parameter int K_SHIFT    = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  output logic             arg_rdy,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [WIDTH-1:0] res
);

  typedef logic signed [WIDTH-1:0] word_t;

  localparam int    OW = $clog2(FIFO_DEPTH + 1);
  localparam int    PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam word_t KM = WIDTH'(K_MUL);

`ifdef FIXP_POLY_SAT_EN
  localparam word_t W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam word_t W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic word_t sat_dbl(input logic signed [2*WIDTH-1:0] v);
    logic [WIDTH:0] top;
    top = v[2*WIDTH-1:WIDTH-1];
    if (top == '0 || top == '1) return word_t'(v);
    return v[2*WIDTH-1] ? W_MIN : W_MAX;
  endfunction

  function automatic word_t sat_sum(input logic signed [WIDTH+1:0] v);
    logic [2:0] top;
    top = v[WIDTH+1:WIDTH-1];
    if (top == 3'b000 || top == 3'b111) return word_t'(v);
    return v[WIDTH+1] ? W_MIN : W_MAX;
  endfunction
`endif

  function automatic word_t mul_w(input word_t x, input word_t y);
    logic signed [2*WIDTH-1:0] f;
    f = (2*WIDTH)'(x) * (2*WIDTH)'(y);
`ifdef FIXP_POLY_SAT_EN
    return sat_dbl(f);
`else
    return word_t'(f);
`endif
  endfunction

  function automatic word_t kb_of(input word_t x);
    logic signed [2*WIDTH-1:0] f;
    f = (2*WIDTH)'(x) * (2*WIDTH)'(KM);
    f = f >>> K_SHIFT;
`ifdef FIXP_POLY_SAT_EN
    return sat_dbl(f);
`else
    return word_t'(f);
`endif
  endfunction

  function automatic word_t sum_of(input word_t p, input word_t k, input word_t cc);
    logic signed [WIDTH+1:0] s;
    s = (WIDTH+2)'(p) + (WIDTH+2)'(k) - (WIDTH+2)'(cc);
`ifdef FIXP_POLY_SAT_EN
    return sat_sum(s);
`else
    return word_t'(s);
`endif
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake: a transfer happens on a rising edge where vld & rdy are both high; rdy never looks at vld.
  logic in_hs, rd_en, wr_en, rdy_q;
  logic [OW-1:0] occ, occ_next, fcnt;
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Stage 0 is the operand register; stages 1..POW do the arithmetic.
  logic  v_q  [0:POW];
  word_t a_q  [0:POW-2];
  word_t c_q  [0:POW-1];
  word_t p_q  [1:POW-1];
  word_t kb_q [1:POW-1];
  word_t b0_q;
  word_t sum_q;
  word_t mem  [0:FIFO_DEPTH-1];

  assign in_hs   = arg_vld & arg_rdy;
  assign arg_rdy = rdy_q & ~rst;
  assign res_vld = ~rst & (fcnt != '0);
  assign rd_en   = res_vld & res_rdy;
  assign res     = res_vld ? mem[rd_ptr] : '0;
  assign wr_en   = v_q[POW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= POW; i++) v_q[i] <= 1'b0;
    end else begin
      v_q[0] <= in_hs;
      for (int i = 1; i <= POW; i++) v_q[i] <= v_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    a_q[0]  <= word_t'(a);
    b0_q    <= word_t'(b);
    c_q[0]  <= word_t'(c);
    p_q[1]  <= mul_w(a_q[0], a_q[0]);
    kb_q[1] <= kb_of(b0_q);
    for (int k = 1; k < POW - 1; k++) a_q[k] <= a_q[k-1];
    for (int k = 1; k < POW; k++) c_q[k] <= c_q[k-1];
    for (int k = 2; k < POW; k++) begin
      p_q[k]  <= mul_w(p_q[k-1], a_q[k-1]);
      kb_q[k] <= kb_q[k-1];
    end
    sum_q <= sum_of(p_q[POW-1], kb_q[POW-1], c_q[POW-1]);
  end

  // Credits cover in-flight plus stored results, so the FIFO cannot overflow.
  always_comb begin
    occ_next = occ;
    if (in_hs && !rd_en)      occ_next = occ + OW'(1);
    else if (!in_hs && rd_en) occ_next = occ - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= '0;
      rdy_q <= 1'b0;
    end else begin
      occ   <= occ_next;
      rdy_q <= (occ_next < OW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_en && !rd_en)      fcnt <= fcnt + OW'(1);
      else if (!wr_en && rd_en) fcnt <= fcnt - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sum_q;
  end

endmodule

// File: tb/tb_fixp_poly_pipe.sv
// Directed and randomized checks of fixp_poly_pipe at default parameters (FIXP_POLY_SAT_EN optional).
module tb_fixp_poly_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        arg_vld;
  logic        arg_rdy;
  logic [31:0] a, b, c;
  logic        res_vld;
  logic        res_rdy;
  logic [31:0] res;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  fixp_poly_pipe dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .a(a), .b(b), .c(c),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res)
  );

  always #5 clk = ~clk;

  // A write while the FIFO already holds 8 results would be an overflow.
  always @(negedge clk) begin
    if (dut.wr_en === 1'b1 && int'(dut.fcnt) >= 8) begin
      bad++;
      $display("FAIL fifo_overflow: fcnt=%0d limit=8", dut.fcnt);
    end
  end

  function automatic logic [31:0] model(input int ta, input int tb, input int tc);
    longint p, kb, s;
    p = 1;
    repeat (5) p = p * ta;
    kb = (longint'(tb) * 77) >>> 8;
    s = p + kb - longint'(tc);
    return s[31:0];
  endfunction

  task automatic run_vec(input int ta, input int tb, input int tc, input int ex, input string nm);
    int lat;
    lat = -1;
    a = ta; b = tb; c = tc; arg_vld = 1'b1; res_rdy = 1'b0;
    total++;
    if (arg_rdy !== 1'b1) begin bad++; $display("FAIL %s_rdy: arg_rdy=%b expected=1", nm, arg_rdy); end
    @(negedge clk);
    arg_vld = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (res_vld === 1'b1) lat = k;
    end
    total++;
    if (lat != 6) begin bad++; $display("FAIL %s_latency: got=%0d expected=6", nm, lat); end
    total++;
    if ($signed(res) !== ex) begin bad++; $display("FAIL %s: res=%0d expected=%0d", nm, $signed(res), ex); end
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    total++;
    if (res_vld !== 1'b0) begin bad++; $display("FAIL %s_drain: res_vld=%b expected=0", nm, res_vld); end
  endtask

  task automatic test_reset();
    rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b0; a = '0; b = '0; c = '0;
    repeat (3) @(negedge clk);
    total++; if (arg_rdy !== 1'b0) begin bad++; $display("FAIL rst_arg_rdy: got=%b expected=0", arg_rdy); end
    total++; if (res_vld !== 1'b0) begin bad++; $display("FAIL rst_res_vld: got=%b expected=0", res_vld); end
    total++; if (res !== 32'd0) begin bad++; $display("FAIL rst_res: got=%0d expected=0", res); end
    total++; if (int'(dut.occ) != 0) begin bad++; $display("FAIL rst_occ: got=%0d expected=0", dut.occ); end
    rst = 1'b0;
    total++; if (arg_rdy !== 1'b0) begin bad++; $display("FAIL rst_first_cycle: arg_rdy=%b expected=0", arg_rdy); end
    @(negedge clk);
    total++; if (arg_rdy !== 1'b1) begin bad++; $display("FAIL rst_release: arg_rdy=%b expected=1", arg_rdy); end
    total++; if (res_vld !== 1'b0) begin bad++; $display("FAIL rst_release_vld: res_vld=%b expected=0", res_vld); end
  endtask

  task automatic test_basic();
    run_vec(1, 4, 3, -1, "basic_1");
    run_vec(2, 10, 100, -65, "basic_2");
  endtask

  task automatic test_negative();
    run_vec(-2, -10, 0, -36, "negative");
  endtask

  task automatic test_overflow();
`ifdef FIXP_POLY_SAT_EN
    run_vec(100, 0, 0, 32'sh7fff_ffff, "sat_pos");
    run_vec(-100, 0, 0, 32'sh8000_0000, "sat_neg");
`else
    run_vec(100, 0, 0, 1410065408, "wrap_pos");
    run_vec(-100, 0, 0, -1410065408, "wrap_neg");
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] p5 [0:7];
    logic [31:0] exp_v;
    int n_acc, n_out;
    p5 = '{32'd0, 32'd1, 32'd32, 32'd243, 32'd1024, 32'd3125, 32'd7776, 32'd16807};
    n_acc = 0;
    res_rdy = 1'b0; a = 0; b = 0; c = 0; arg_vld = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (arg_rdy === 1'b1) begin
        exp_q.push_back(n_acc < 8 ? p5[n_acc] : 32'hdead_beef);
        n_acc++;
      end
      @(negedge clk);
      a = n_acc;
    end
    arg_vld = 1'b0;
    total++; if (n_acc != 8) begin bad++; $display("FAIL bp_accepts: got=%0d expected=8", n_acc); end
    total++; if (arg_rdy !== 1'b0) begin bad++; $display("FAIL bp_arg_rdy: got=%b expected=0", arg_rdy); end
    total++; if (res_vld !== 1'b1) begin bad++; $display("FAIL bp_res_vld: got=%b expected=1", res_vld); end
    res_rdy = 1'b1;
    n_out = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 1) begin
        total++;
        if (arg_rdy !== 1'b1) begin bad++; $display("FAIL bp_rdy_reraise: arg_rdy=%b expected=1", arg_rdy); end
      end
      if (res_vld === 1'b1) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
        total++;
        if (res !== exp_v) begin bad++; $display("FAIL bp_result_%0d: res=%0d expected=%0d", n_out, res, exp_v); end
        n_out++;
      end
      @(negedge clk);
    end
    res_rdy = 1'b0;
    total++; if (n_out != 8) begin bad++; $display("FAIL bp_drain_count: got=%0d expected=8", n_out); end
    total++; if (res_vld !== 1'b0) begin bad++; $display("FAIL bp_drain_vld: got=%b expected=0", res_vld); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int n, seen;
    n = 0;
    res_rdy = 1'b0; arg_vld = 1'b1; b = 0; c = 0;
    for (int k = 0; k < 20 && n < 5; k++) begin
      a = k + 1;
      if (arg_rdy === 1'b1) n++;
      @(negedge clk);
    end
    arg_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (arg_rdy !== 1'b0) begin bad++; $display("FAIL mid_rst_first: arg_rdy=%b expected=0", arg_rdy); end
    total++; if (int'(dut.occ) != 0) begin bad++; $display("FAIL mid_rst_occ: got=%0d expected=0", dut.occ); end
    @(negedge clk);
    total++; if (arg_rdy !== 1'b1) begin bad++; $display("FAIL mid_rst_release: arg_rdy=%b expected=1", arg_rdy); end
    res_rdy = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (res_vld !== 1'b0) seen++;
    end
    res_rdy = 1'b0;
    total++; if (seen != 0) begin bad++; $display("FAIL mid_rst_leak: results=%0d expected=0", seen); end
    run_vec(3, 256, 5, 315, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v;
    int n_in, n_out, low, first, last;
    n_in = 0; n_out = 0; low = 0; first = -1; last = -1;
    res_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (n_in < 10) begin
        a = n_in + 1; b = (n_in + 1) * 100; c = n_in + 1; arg_vld = 1'b1;
      end else begin
        arg_vld = 1'b0;
      end
      if (arg_vld) begin
        if (arg_rdy === 1'b1) begin
          exp_q.push_back(model(n_in + 1, (n_in + 1) * 100, n_in + 1));
          n_in++;
        end else begin
          low++;
        end
      end
      if (res_vld === 1'b1) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
        total++;
        if (res !== exp_v) begin bad++; $display("FAIL b2b_result_%0d: res=%0d expected=%0d", n_out, res, exp_v); end
        if (first < 0) first = k;
        last = k;
        n_out++;
      end
      @(negedge clk);
    end
    arg_vld = 1'b0; res_rdy = 1'b0;
    total++; if (low != 0) begin bad++; $display("FAIL b2b_stall: stall_cycles=%0d expected=0", low); end
    total++; if (n_out != 10) begin bad++; $display("FAIL b2b_count: got=%0d expected=10", n_out); end
    total++; if (last - first != 9) begin bad++; $display("FAIL b2b_throughput: span=%0d expected=9", last - first); end
    exp_q.delete();
  endtask

  task automatic test_random_stress();
    logic [31:0] exp_v, hold_val;
    logic hold_prev, acc_last;
    int n_in, n_out, ta, tb, tc, cyc;
    n_in = 0; n_out = 0; hold_prev = 1'b0; acc_last = 1'b0; hold_val = '0; cyc = 0;
    arg_vld = 1'b0;
    while (n_out < 1000 && cyc < 20000) begin
      if (hold_prev) begin
        total++;
        if (res_vld !== 1'b1 || res !== hold_val) begin
          bad++;
          $display("FAIL stress_hold: res_vld=%b res=%0d expected vld=1 res=%0d", res_vld, res, hold_val);
        end
      end
      if (!arg_vld || acc_last) begin
        if (n_in < 1000 && $urandom_range(0, 3) != 0) begin
          ta = int'($urandom_range(0, 140)) - 70;
          tb = int'($urandom_range(0, 2097152)) - 1048576;
          tc = int'($urandom_range(0, 2097152)) - 1048576;
          a = ta; b = tb; c = tc; arg_vld = 1'b1;
        end else begin
          arg_vld = 1'b0;
        end
      end
      res_rdy = ($urandom_range(0, 2) != 0);
      acc_last = arg_vld && (arg_rdy === 1'b1);
      if (acc_last) begin
        exp_q.push_back(model(ta, tb, tc));
        n_in++;
      end
      if (res_vld === 1'b1 && res_rdy) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
        total++;
        if (res !== exp_v) begin bad++; $display("FAIL stress_result_%0d: res=%0d expected=%0d", n_out, res, exp_v); end
        n_out++;
      end
      hold_prev = (res_vld === 1'b1) && !res_rdy;
      hold_val  = res;
      @(negedge clk);
      cyc++;
    end
    arg_vld = 1'b0; res_rdy = 1'b0;
    total++; if (n_in != 1000) begin bad++; $display("FAIL stress_in_count: got=%0d expected=1000", n_in); end
    total++; if (n_out != 1000) begin bad++; $display("FAIL stress_out_count: got=%0d expected=1000", n_out); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stress_leftover: got=%0d expected=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
